// File: rtl/rob_commit_unit_if.sv
// -----------------------------------------------------------------------------
// rob_commit_unit_if
// Bundle of every non-clock/non-reset signal of the reorder buffer.
//   master : issue / execute / regbank side (drives alloc, CDB, lookup, flush)
//   slave  : the reorder buffer itself
// Signals:
//   alloc_valid/alloc_dest   -> allocate request and destination register
//   alloc_ready/alloc_tag    <- space available, tag granted (tail pointer)
//   cdb_valid/cdb_tag/data   -> common-data-bus result broadcast
//   rd_tag                   -> operand lookup tag
//   rd_ready/rd_data         <- lookup result (entry busy and done, value)
//   commit_valid/dest/data/tag <- registered in-order retire pulse
//   flush                    -> discard all entries
//   count                    <- occupied entries 0..DEPTH
// -----------------------------------------------------------------------------
interface rob_commit_unit_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int TAG_W  = 3
);
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              commit_valid;
  logic [REG_W-1:0]  commit_dest;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;
  logic              flush;
  logic [TAG_W:0]    count;

  modport master (
    output alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, rd_tag, flush,
    input  alloc_ready, alloc_tag, rd_ready, rd_data,
           commit_valid, commit_dest, commit_data, commit_tag, count
  );

  modport slave (
    input  alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data, rd_tag, flush,
    output alloc_ready, alloc_tag, rd_ready, rd_data,
           commit_valid, commit_dest, commit_data, commit_tag, count
  );
endinterface

// File: rtl/rob_commit_unit.sv
// -----------------------------------------------------------------------------
// rob_commit_unit
// 8-entry reorder buffer with in-order commit. Issue allocates at the tail,
// CDB results mark entries done out of order, and the head entry retires one
// cycle after it is seen busy+done. A combinational lookup exposes completed
// but not yet committed values for operand forwarding.
// Ports:
//   clk1  : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : rob_commit_unit_if.slave (alloc / CDB / lookup / commit / flush)
// -----------------------------------------------------------------------------
module rob_commit_unit #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3
) (
  input logic               clk1,
  input logic               rst_n,
  rob_commit_unit_if.slave  bus
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE  = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [TAG_W-1:0] TAG_ONE  = {{(TAG_W-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [REG_W-1:0]  dest_q [DEPTH];
  logic [REG_W-1:0]  dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              commit_valid_q, commit_valid_d;
  logic [REG_W-1:0]  commit_dest_q, commit_dest_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;

  logic alloc_fire_s;
  logic cdb_fire_s;
  logic commit_fire_s;

  // alloc_ready uses the pre-edge count only, so a commit never frees a slot
  // for an allocate in the same cycle.
  assign alloc_fire_s  = bus.alloc_valid && (count_q != FULL_CNT);
  assign cdb_fire_s    = bus.cdb_valid && busy_q[bus.cdb_tag] && !done_q[bus.cdb_tag];
  assign commit_fire_s = busy_q[head_q] && done_q[head_q];

  assign bus.alloc_ready  = (count_q != FULL_CNT);
  assign bus.alloc_tag    = tail_q;
  assign bus.rd_ready     = busy_q[bus.rd_tag] && done_q[bus.rd_tag];
  assign bus.rd_data      = data_q[bus.rd_tag];
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_dest  = commit_dest_q;
  assign bus.commit_data  = commit_data_q;
  assign bus.commit_tag   = commit_tag_q;
  assign bus.count        = count_q;

  // Next-state for entries, pointers, occupancy and the commit register.
  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    dest_d         = dest_q;
    data_d         = data_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_dest_d  = commit_dest_q;
    commit_data_d  = commit_data_q;
    commit_tag_d   = commit_tag_q;

    if (bus.flush) begin
      // Flush wins over alloc, CDB and commit; commit outputs other than
      // the valid pulse keep their last values.
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Writeback. A CDB aimed at the tail being allocated cannot fire since
      // that entry is not busy, so ordering against allocate is irrelevant.
      if (cdb_fire_s) begin
        done_d[bus.cdb_tag] = 1'b1;
        data_d[bus.cdb_tag] = bus.cdb_data;
      end else begin
        data_d = data_q;
      end

      if (alloc_fire_s) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        dest_d[tail_q] = bus.alloc_dest;
        tail_d         = tail_q + TAG_ONE;
      end else begin
        tail_d = tail_q;
      end

      // Commit looks only at registered done, so there is no CDB bypass.
      if (commit_fire_s) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + TAG_ONE;
        commit_valid_d = 1'b1;
        commit_dest_d  = dest_q[head_q];
        commit_data_d  = data_q[head_q];
        commit_tag_d   = head_q;
      end else begin
        commit_valid_d = 1'b0;
      end

      case ({alloc_fire_s, commit_fire_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      busy_q         <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_dest_q  <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_dest_q  <= commit_dest_d;
      commit_data_q  <= commit_data_d;
      commit_tag_q   <= commit_tag_d;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= dest_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_rob_commit_unit
// Directed bench for the reorder buffer: a vector table for in-order retire
// of out-of-order results, then hand sequences for alloc+commit overlap,
// stale CDB, flush, full, and pointer wrap-around.
// -----------------------------------------------------------------------------
module tb_rob_commit_unit;

  logic clk1 = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk1 = ~clk1;

  rob_commit_unit_if bus ();

  rob_commit_unit dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        av;
    logic [3:0]  ad;
    logic        cv;
    logic [2:0]  ct;
    logic [15:0] cd;
    logic [2:0]  rt;
    logic [3:0]  e_cnt;
    logic        e_ar;
    logic [2:0]  e_at;
    logic        e_cv;
    logic [3:0]  e_cdst;
    logic [15:0] e_cdat;
    logic [2:0]  e_ctag;
    logic        e_rr;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic chk_commit(input string name, input int tag, input int dest, input int data);
    chk({name, "_cv"},   {31'd0, bus.commit_valid}, 32'd1);
    chk({name, "_ctag"}, {29'd0, bus.commit_tag},   tag);
    chk({name, "_cdst"}, {28'd0, bus.commit_dest},  dest);
    chk({name, "_cdat"}, {16'd0, bus.commit_data},  data);
  endtask

  initial begin
    // av ad     cv    ct    cd        rt  | cnt ar    at    cv    cdst  cdat      ctag  rr    rd
    vecs[0] = '{1'b1, 4'd3, 1'b0, 3'd0, 16'h0000, 3'd0, 4'd1, 1'b1, 3'd1, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 4'd5, 1'b0, 3'd0, 16'h0000, 3'd0, 4'd2, 1'b1, 3'd2, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 4'd7, 1'b0, 3'd0, 16'h0000, 3'd0, 4'd3, 1'b1, 3'd3, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 4'd0, 1'b1, 3'd2, 16'h0022, 3'd2, 4'd3, 1'b1, 3'd3, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b1, 16'h0022};
    vecs[4] = '{1'b0, 4'd0, 1'b1, 3'd1, 16'h0011, 3'd1, 4'd3, 1'b1, 3'd3, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b1, 16'h0011};
    vecs[5] = '{1'b0, 4'd0, 1'b1, 3'd0, 16'h0010, 3'd0, 4'd3, 1'b1, 3'd3, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b1, 16'h0010};
    vecs[6] = '{1'b0, 4'd0, 1'b0, 3'd0, 16'h0000, 3'd1, 4'd2, 1'b1, 3'd3, 1'b1, 4'd3, 16'h0010, 3'd0, 1'b1, 16'h0011};
    vecs[7] = '{1'b0, 4'd0, 1'b0, 3'd0, 16'h0000, 3'd2, 4'd1, 1'b1, 3'd3, 1'b1, 4'd5, 16'h0011, 3'd1, 1'b1, 16'h0022};
    vecs[8] = '{1'b0, 4'd0, 1'b0, 3'd0, 16'h0000, 3'd2, 4'd0, 1'b1, 3'd3, 1'b1, 4'd7, 16'h0022, 3'd2, 1'b0, 16'h0022};
    vecs[9] = '{1'b0, 4'd0, 1'b1, 3'd1, 16'h0099, 3'd1, 4'd0, 1'b1, 3'd3, 1'b0, 4'd7, 16'h0022, 3'd2, 1'b0, 16'h0011};

    rst_n          = 1'b0;
    bus.alloc_dest = 4'd0;
    bus.cdb_tag    = 3'd0;
    bus.cdb_data   = 16'h0000;
    bus.rd_tag     = 3'd0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_count", {28'd0, bus.count},        32'd0);
    chk("rst_ready", {31'd0, bus.alloc_ready},  32'd1);
    chk("rst_cv",    {31'd0, bus.commit_valid}, 32'd0);
    chk("rst_atag",  {29'd0, bus.alloc_tag},    32'd0);
    chk("rst_cdat",  {16'd0, bus.commit_data},  32'd0);

    // In-order retire of out-of-order completions.
    for (int i = 0; i < 10; i++) begin
      bus.alloc_valid = vecs[i].av;
      bus.alloc_dest  = vecs[i].ad;
      bus.cdb_valid   = vecs[i].cv;
      bus.cdb_tag     = vecs[i].ct;
      bus.cdb_data    = vecs[i].cd;
      bus.rd_tag      = vecs[i].rt;
      tick();
      idle();
      chk($sformatf("v%0d_count", i), {28'd0, bus.count},        {28'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d_ready", i), {31'd0, bus.alloc_ready},  {31'd0, vecs[i].e_ar});
      chk($sformatf("v%0d_atag", i),  {29'd0, bus.alloc_tag},    {29'd0, vecs[i].e_at});
      chk($sformatf("v%0d_cv", i),    {31'd0, bus.commit_valid}, {31'd0, vecs[i].e_cv});
      chk($sformatf("v%0d_cdst", i),  {28'd0, bus.commit_dest},  {28'd0, vecs[i].e_cdst});
      chk($sformatf("v%0d_cdat", i),  {16'd0, bus.commit_data},  {16'd0, vecs[i].e_cdat});
      chk($sformatf("v%0d_ctag", i),  {29'd0, bus.commit_tag},   {29'd0, vecs[i].e_ctag});
      chk($sformatf("v%0d_rrdy", i),  {31'd0, bus.rd_ready},     {31'd0, vecs[i].e_rr});
      chk($sformatf("v%0d_rdat", i),  {16'd0, bus.rd_data},      {16'd0, vecs[i].e_rd});
    end

    // Simultaneous alloc + commit at count 4 (head=tail=3 here).
    for (int i = 0; i < 4; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_dest  = 4'(i + 1);
      chk($sformatf("sim_atag%0d", i), {29'd0, bus.alloc_tag}, 32'(3 + i));
      tick();
    end
    idle();
    chk("sim_count4", {28'd0, bus.count}, 32'd4);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd3;
    bus.cdb_data  = 16'h0033;
    tick();
    idle();
    chk("sim_cdb_cv", {31'd0, bus.commit_valid}, 32'd0);
    bus.alloc_valid = 1'b1;
    bus.alloc_dest  = 4'd9;
    chk("sim_atag_pre", {29'd0, bus.alloc_tag}, 32'd7);
    tick();
    idle();
    chk_commit("sim_commit", 3, 1, 32'h33);
    chk("sim_count_kept", {28'd0, bus.count},     32'd4);
    chk("sim_atag_post",  {29'd0, bus.alloc_tag}, 32'd0);

    // Stale CDB to the just-committed tag.
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd3;
    bus.cdb_data  = 16'h0077;
    bus.rd_tag    = 3'd3;
    tick();
    idle();
    chk("stale_cv",    {31'd0, bus.commit_valid}, 32'd0);
    chk("stale_count", {28'd0, bus.count},        32'd4);
    chk("stale_rrdy",  {31'd0, bus.rd_ready},     32'd0);
    chk("stale_rdat",  {16'd0, bus.rd_data},      32'h33);
    tick();
    chk("stale_cv2",   {31'd0, bus.commit_valid}, 32'd0);

    // Flush mid-flight: 5 entries (tags 4..7,0), tags 5 and 6 done.
    bus.alloc_valid = 1'b1;
    bus.alloc_dest  = 4'hA;
    tick();
    idle();
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd5;
    bus.cdb_data  = 16'h0055;
    tick();
    bus.cdb_tag   = 3'd6;
    bus.cdb_data  = 16'h0066;
    tick();
    idle();
    bus.rd_tag = 3'd6;
    #1;
    chk("fl_pre_rrdy",  {31'd0, bus.rd_ready},     32'd1);
    chk("fl_pre_rdat",  {16'd0, bus.rd_data},      32'h66);
    chk("fl_pre_count", {28'd0, bus.count},        32'd5);
    chk("fl_pre_cv",    {31'd0, bus.commit_valid}, 32'd0);
    bus.flush       = 1'b1;
    bus.cdb_valid   = 1'b1;
    bus.cdb_tag     = 3'd4;
    bus.cdb_data    = 16'h0044;
    bus.alloc_valid = 1'b1;
    bus.alloc_dest  = 4'hF;
    tick();
    idle();
    chk("fl_count", {28'd0, bus.count},        32'd0);
    chk("fl_cv",    {31'd0, bus.commit_valid}, 32'd0);
    chk("fl_atag",  {29'd0, bus.alloc_tag},    32'd0);
    chk("fl_ready", {31'd0, bus.alloc_ready},  32'd1);
    chk("fl_ctag",  {29'd0, bus.commit_tag},   32'd3);
    for (int t = 0; t < 8; t++) begin
      bus.rd_tag = 3'(t);
      #1;
      chk($sformatf("fl_rrdy%0d", t), {31'd0, bus.rd_ready}, 32'd0);
    end
    tick();
    chk("fl_cv2",    {31'd0, bus.commit_valid}, 32'd0);
    chk("fl_count2", {28'd0, bus.count},        32'd0);

    // Full: 8 allocations from tag 0.
    for (int i = 0; i < 8; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_dest  = 4'(i + 1);
      chk($sformatf("full_atag%0d", i), {29'd0, bus.alloc_tag}, 32'(i));
      tick();
    end
    idle();
    chk("full_count", {28'd0, bus.count},       32'd8);
    chk("full_ready", {31'd0, bus.alloc_ready}, 32'd0);
    bus.alloc_valid = 1'b1;
    bus.alloc_dest  = 4'hF;
    tick();
    idle();
    chk("full_9th_count", {28'd0, bus.count},     32'd8);
    chk("full_9th_atag",  {29'd0, bus.alloc_tag}, 32'd0);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd0;
    bus.cdb_data  = 16'h00A0;
    tick();
    idle();
    chk("full_cdb_count", {28'd0, bus.count},       32'd8);
    chk("full_cdb_ready", {31'd0, bus.alloc_ready}, 32'd0);
    // Commit this cycle must not let the alloc in.
    bus.alloc_valid = 1'b1;
    bus.alloc_dest  = 4'hE;
    tick();
    idle();
    chk_commit("full_commit", 0, 1, 32'hA0);
    chk("full_commit_count", {28'd0, bus.count},       32'd7);
    chk("full_commit_ready", {31'd0, bus.alloc_ready}, 32'd1);
    chk("full_commit_atag",  {29'd0, bus.alloc_tag},   32'd0);

    // Retire the remaining 7; each commits one cycle after its CDB.
    for (int k = 0; k < 7; k++) begin
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = 3'(k + 1);
      bus.cdb_data  = 16'(32'hA1 + k);
      tick();
      if (k == 0) begin
        chk("ret_cv0", {31'd0, bus.commit_valid}, 32'd0);
      end else begin
        chk_commit($sformatf("ret%0d", k), k, k + 1, 32'hA0 + k);
      end
    end
    idle();
    tick();
    chk_commit("ret7", 7, 8, 32'hA7);
    chk("ret_count", {28'd0, bus.count},     32'd0);
    chk("ret_atag",  {29'd0, bus.alloc_tag}, 32'd0);

    // Wrap: tags 0,1,2 reused, then retired so both pointers end at 3.
    for (int i = 0; i < 3; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_dest  = 4'(11 + i);
      chk($sformatf("wrap_atag%0d", i), {29'd0, bus.alloc_tag}, 32'(i));
      tick();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = 3'(k);
      bus.cdb_data  = 16'(32'hB0 + k);
      tick();
      if (k > 0) begin
        chk_commit($sformatf("wrap_ret%0d", k - 1), k - 1, 11 + k - 1, 32'hB0 + k - 1);
      end else begin
        chk("wrap_cv0", {31'd0, bus.commit_valid}, 32'd0);
      end
    end
    idle();
    tick();
    chk_commit("wrap_ret2", 2, 13, 32'hB2);
    chk("wrap_count", {28'd0, bus.count},     32'd0);
    chk("wrap_atag",  {29'd0, bus.alloc_tag}, 32'd3);
    tick();
    chk("wrap_cv_end", {31'd0, bus.commit_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- 8-entry reorder buffer with in-order commit stage for the Tomasulo core.
- Sits downstream of the add/mul reservation-station execute units. Consumes their common-data-bus (CDB) results and retires them in program order to the register bank.
- Issue allocates entries at the tail. Commit drains from the head.
- Also provides a combinational tag lookup so issue can forward completed-but-uncommitted values.

Parameters:
- DATA_W, 16, width of result data.
- REG_W, 4, register index width (16 architectural registers).
- DEPTH, 8, ROB entries; fixed power of two.
- TAG_W, 3, log2(DEPTH).

Ports:
- clk1  input  1  single clock, rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- alloc_valid  input  1  issue requests an entry this cycle.
- alloc_dest  input  REG_W  destination register of issuing instruction.
- alloc_ready  output  1  ROB not full; combinational from count.
- alloc_tag  output  TAG_W  tag granted (= tail pointer); valid when alloc_valid && alloc_ready.
- cdb_valid  input  1  execute unit broadcasts a result.
- cdb_tag  input  TAG_W  ROB tag of broadcast result.
- cdb_data  input  DATA_W  result value.
- rd_tag  input  TAG_W  operand lookup tag.
- rd_ready  output  1  entry rd_tag is busy and done; combinational.
- rd_data  output  DATA_W  stored value of entry rd_tag; combinational.
- commit_valid  output  1  registered one-cycle retire pulse.
- commit_dest  output  REG_W  register to write.
- commit_data  output  DATA_W  value to write.
- commit_tag  output  TAG_W  tag retired; issue clears matching regbank tag.
- flush  input  1  discard all entries (branch mispredict).
- count  output  TAG_W+1  occupied entries, 0..8.

Behaviour:
- Per-entry state: busy, done, dest[REG_W], data[DATA_W]. Pointers head_p and tail_p are TAG_W wide and wrap modulo DEPTH. count is kept explicitly to disambiguate full from empty.
- Reset (rst_n=0 at a clk1 edge): all busy=0, done=0, head_p=0, tail_p=0, count=0, commit_valid=0, commit_dest=0, commit_data=0, commit_tag=0. Reset takes priority over every other input, including mid-operation; in-flight entries are lost.
- Allocate: when alloc_valid && alloc_ready, entry[tail_p] gets busy=1, done=0, dest=alloc_dest. tail_p then increments. alloc_ready = (count != DEPTH). While full, alloc_valid is ignored with no state change.
- Writeback: when cdb_valid, and entry[cdb_tag] is busy and not done, set done=1 and data=cdb_data.
  - CDB to a non-busy or already-done entry is ignored.
  - Only one CDB broadcast per cycle.
- Commit:
  - Each cycle, if entry[head_p] is busy && done (as registered at the start of the cycle), next cycle has commit_valid=1 with dest, data and tag of that entry. busy and done clear, and head_p increments.
  - Otherwise commit_valid=0; the other commit outputs hold their last values.
  - At most one commit per cycle.
  - No CDB-to-commit bypass: a result written at the head in cycle N commits at the edge of cycle N+1 at the earliest, so commit latency after the CDB edge is 1 cycle.
- Simultaneous allocate + commit: count unchanged; both pointers advance.
  - A commit in the same cycle does not free space for an allocate while full. alloc_ready reflects pre-edge count only.
- Allocate to an entry whose tag equals cdb_tag in the same cycle is impossible by construction, since the entry is not busy. The CDB write is dropped.
- Lookup: rd_ready = busy[rd_tag] && done[rd_tag]; rd_data = data[rd_tag]. Pure combinational read of registered state, with no CDB bypass.
- Flush: synchronous. On the flush edge, all busy/done clear, head_p=tail_p=0, count=0, commit_valid=0. Flush has priority over alloc, CDB and commit in the same cycle. Commits already emitted stand.
- Wrap-around: pointers go 7 -> 0 silently. Tags are reused only after the entry commits.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> count=0, alloc_ready=1, commit_valid=0, alloc_tag=0.
- In-order retire with out-of-order completion: alloc dest 3, 5, 7 (tags 0,1,2); CDB tag2=0x22, tag1=0x11, tag0=0x10 on successive cycles -> commits follow tag 0,1,2 on three consecutive cycles after tag0's CDB, dests 3,5,7, data 0x10,0x11,0x22.
- Full: 8 allocs without CDB -> count=8, alloc_ready=0. A 9th alloc_valid changes nothing. CDB to head plus commit, then alloc_ready=1 on the following cycle.
- Wrap: fill 8, retire 8, alloc 3 more -> tags 0,1,2 granted again. head_p and tail_p end at 3 after commits.
- Simultaneous alloc+commit with count=4 -> count stays 4, both pointers advance by 1. Stale CDB to an already-committed tag -> ignored, no extra commit.
- Flush mid-flight: 5 entries, 2 done, assert flush together with cdb_valid -> next cycle count=0, commit_valid=0, rd_ready=0 for all tags, alloc_tag=0.
